// File: rtl/usb_tx_sched_pkg.sv
// Shared types and constants for the USB transmit scheduler.
// States, CRC16 parameters and token/data PIDs.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    DATA,
    CRC1,
    CRC2,
    GAP
  } state_e;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  localparam logic [3:0] OUT   = 4'h1;
  localparam logic [3:0] IN    = 4'h9;
  localparam logic [3:0] DATA0 = 4'h3;
  localparam logic [3:0] DATA1 = 4'hB;

endpackage

// File: rtl/usb_tx_sched_if.sv
// Byte-wide valid/ready link from the scheduler
// to the USB TX line interface.
interface usb_tx_sched_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/usb_crc16_byte.sv
// One-byte step of CRC-16/USB, reflected, LSB first.
// Purely combinational.
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_R;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_sched.sv
// Round-robin USB TX byte-path scheduler:
// PID, payload, CRC16 (lo, hi), then an idle gap.
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 7,
  parameter int MAX_LEN = 64,
  parameter int GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [4*NUM_REQ-1:0]     req_pid,
  input  logic [LEN_W*NUM_REQ-1:0] req_len,
  input  logic [8*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     rd_en,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  usb_tx_sched_if.master           tx
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [PTR_W-1:0]   p
  );
    logic [PTR_W-1:0] w;
    logic             hit;
    int               idx;
    w   = p;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        w   = PTR_W'(idx);
      end
    end
    return w;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         pid_q, pid_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        crc_q, crc_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [PTR_W-1:0] win;
  logic [LEN_W-1:0] win_len_raw, win_len;
  logic [7:0]       own_byte;
  logic [15:0]      crc_nx;
  logic [7:0]       tx_data_c;
  logic             tx_valid_c;
  logic             xfer;

  assign win         = rr_pick(req, ptr_q);
  assign win_len_raw = req_len[int'(win)*LEN_W +: LEN_W];
  assign win_len     = (win_len_raw > MAX_L) ? MAX_L : win_len_raw;
  assign own_byte    = req_data[int'(ptr_q)*8 +: 8];

  usb_crc16_byte u_crc (
    .crc_in (crc_q),
    .data   (own_byte),
    .crc_out(crc_nx)
  );

  assign tx_valid_c = (state_q == PID)  || (state_q == DATA) ||
                      (state_q == CRC1) || (state_q == CRC2);
  assign xfer       = tx_valid_c && tx.tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      pid_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= CRC16_INIT;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    pid_d     = pid_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    gap_d     = gap_q;
    tx_data_c = '0;
    rd_en     = 1'b0;
    done      = '0;
    unique case (state_q)
      IDLE: begin
        crc_d = CRC16_INIT;
        if (|req) begin
          grant_d = NUM_REQ'(1) << win;
          ptr_d   = win;
          pid_d   = req_pid[int'(win)*4 +: 4];
          len_d   = win_len;
          cnt_d   = win_len;
          state_d = PID;
        end
      end
      PID: begin
        tx_data_c = {~pid_q, pid_q};
        if (xfer) state_d = (len_q != '0) ? DATA : CRC1;
      end
      DATA: begin
        tx_data_c = own_byte;
        rd_en     = xfer;
        if (xfer) begin
          cnt_d = cnt_q - 1'b1;
          crc_d = crc_nx;
          if (cnt_q == LEN_W'(1)) state_d = CRC1;
        end
      end
      CRC1: begin
        tx_data_c = ~crc_q[7:0];
        if (xfer) state_d = CRC2;
      end
      CRC2: begin
        tx_data_c = ~crc_q[15:8];
        if (xfer) begin
          done    = grant_q;
          grant_d = '0;
          gap_d   = GAP_W'(GAP_CYC);
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign tx.tx_data  = tx_data_c;
  assign tx.tx_valid = tx_valid_c;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: sequencing, CRC,
// round-robin, backpressure, clamping and reset abort.
module tb_usb_tx_sched;

  localparam int NR = 4;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [4*NR-1:0]  req_pid;
  logic [LW*NR-1:0] req_len;
  logic [8*NR-1:0]  req_data;
  logic [NR-1:0] grant;
  logic          rd_en;
  logic [NR-1:0] done;
  logic          busy;

  usb_tx_sched_if txi ();

  usb_tx_sched #(
    .NUM_REQ(NR), .LEN_W(LW), .MAX_LEN(64), .GAP_CYC(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_pid (req_pid),
    .req_len (req_len),
    .req_data(req_data),
    .grant   (grant),
    .rd_en   (rd_en),
    .done    (done),
    .busy    (busy),
    .tx      (txi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [NR][128];
  int         idx [NR];

  logic [7:0]    cap [$];
  int            rd_cnt, rd_bad, hold_viol, stall_cnt;
  logic [NR-1:0] done_vec, grant_pid;
  bit            timeout;

  task automatic drive_data();
    for (int i = 0; i < NR; i++)
      req_data[i*8 +: 8] = mem[i][idx[i]];
  endtask

  task automatic clear_idx();
    for (int i = 0; i < NR; i++) idx[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    txi.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs the line side until one packet completes (done seen)
  task automatic capture(input int bound, input bit toggle,
                         input bit drop_mid);
    bit         got, prev_stall, dropped;
    logic [7:0] prev_data;
    int         own;
    cap.delete();
    rd_cnt = 0; rd_bad = 0; hold_viol = 0; stall_cnt = 0;
    done_vec = '0; grant_pid = '0; timeout = 1'b0;
    got = 1'b0; prev_stall = 1'b0; prev_data = '0; dropped = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      txi.tx_ready = toggle ? ~txi.tx_ready : 1'b1;
      drive_data();
      #1;
      if (prev_stall && (!txi.tx_valid || txi.tx_data !== prev_data))
        hold_viol++;
      prev_stall = txi.tx_valid && !txi.tx_ready;
      if (prev_stall) stall_cnt++;
      prev_data = txi.tx_data;
      if (txi.tx_valid && grant_pid == '0) grant_pid = grant;
      if (txi.tx_valid && txi.tx_ready) cap.push_back(txi.tx_data);
      if (rd_en) begin
        if (!(txi.tx_valid && txi.tx_ready)) rd_bad++;
        rd_cnt++;
        own = 0;
        for (int i = 0; i < NR; i++) if (grant[i]) own = i;
        idx[own]++;
        if (drop_mid && !dropped) begin
          dropped = 1'b1;
          req = '0;
          req_len[2*LW +: LW] = 7'd1;
        end
      end
      if (done != '0) begin
        done_vec = done;
        got = 1'b1;
      end
    end
    timeout = !got;
  endtask

  task automatic test_reset();
    req_pid = '0; req_len = '0; req_data = '0;
    do_reset();
    #1;
    checks++;
    if ({grant, rd_en, done, busy, txi.tx_valid} !== '0 ||
        txi.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: grant=%b rd=%b done=%b busy=%b v=%b d=%h want all 0",
               grant, rd_en, done, busy, txi.tx_valid, txi.tx_data);
    end
  endtask

  task automatic test_zero_len();
    bit gap_ok;
    do_reset();
    clear_idx();
    req_pid[3:0] = 4'h3;
    req_len[LW-1:0] = 7'd0;
    req = 4'b0001;
    capture(40, 1'b0, 1'b0);
    req = '0;
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL zl_timeout: no done within bound");
    end
    checks++;
    if (cap.size() != 3 || cap[0] !== 8'hC3 || cap[1] !== 8'h00 ||
        cap[2] !== 8'h00) begin
      errors++;
      $display("FAIL zl_bytes: got %p want C3 00 00", cap);
    end
    checks++;
    if (grant_pid !== 4'b0001) begin
      errors++;
      $display("FAIL zl_grant: got %b want 0001", grant_pid);
    end
    checks++;
    if (done_vec !== 4'b0001) begin
      errors++;
      $display("FAIL zl_done: got %b want 0001", done_vec);
    end
    gap_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      txi.tx_ready = 1'b1;
      #1;
      if (txi.tx_valid !== 1'b0 || done !== '0 || busy !== 1'b1)
        gap_ok = 1'b0;
    end
    checks++;
    if (!gap_ok) begin
      errors++;
      $display("FAIL zl_gap: got valid/done activity or idle in gap, want 4 busy idle cycles");
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zl_gap_end: busy=%b want 0 after gap", busy);
    end
  endtask

  task automatic test_crc_len9();
    logic [7:0] exp [12];
    bool_ok: begin end
    exp[0] = 8'h4B;
    for (int k = 0; k < 9; k++) begin
      exp[k+1]  = 8'h31 + 8'(k);
      mem[1][k] = 8'h31 + 8'(k);
    end
    exp[10] = 8'hC8;
    exp[11] = 8'hB4;
    do_reset();
    clear_idx();
    req_pid[7:4] = 4'hB;
    req_len[LW +: LW] = 7'd9;
    req = 4'b0010;
    capture(60, 1'b0, 1'b0);
    req = '0;
    checks++;
    if (timeout || cap.size() != 12) begin
      errors++;
      $display("FAIL l9_count: got %0d bytes timeout=%b want 12", cap.size(), timeout);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (k >= cap.size() || cap[k] !== exp[k]) begin
        errors++;
        $display("FAIL l9_byte%0d: got %h want %h", k,
                 (k < cap.size()) ? cap[k] : 8'hxx, exp[k]);
      end
    end
    checks++;
    if (rd_cnt != 9 || rd_bad != 0) begin
      errors++;
      $display("FAIL l9_rd_en: got %0d (bad %0d) want 9 (0)", rd_cnt, rd_bad);
    end
    checks++;
    if (done_vec !== 4'b0010) begin
      errors++;
      $display("FAIL l9_done: got %b want 0010", done_vec);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    clear_idx();
    req_pid = {4'h9, 4'h1, 4'hB, 4'h3};
    req_len = {7'd1, 7'd1, 7'd1, 7'd1};
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      capture(40, 1'b0, 1'b0);
      checks++;
      if (timeout || grant_pid !== exp_g[p] || done_vec !== exp_g[p] ||
          cap.size() != 4) begin
        errors++;
        $display("FAIL rr_pkt%0d: grant=%b done=%b bytes=%0d want %b %b 4",
                 p, grant_pid, done_vec, cap.size(), exp_g[p], exp_g[p]);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_idx();
    mem[0][0] = 8'hA5;
    mem[0][1] = 8'h5A;
    req_pid[3:0] = 4'h3;
    req_len[LW-1:0] = 7'd2;
    req = 4'b0001;
    txi.tx_ready = 1'b1;
    capture(60, 1'b1, 1'b0);
    req = '0;
    checks++;
    if (timeout || cap.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d transfers want 5", cap.size());
    end
    checks++;
    if (cap.size() < 3 || cap[0] !== 8'hC3 || cap[1] !== 8'hA5 ||
        cap[2] !== 8'h5A) begin
      errors++;
      $display("FAIL bp_bytes: got %p want C3 A5 5A ...", cap);
    end
    checks++;
    if (hold_viol != 0 || stall_cnt == 0) begin
      errors++;
      $display("FAIL bp_hold: violations=%0d stalls=%0d want 0 and >0",
               hold_viol, stall_cnt);
    end
    checks++;
    if (rd_cnt != 2 || rd_bad != 0) begin
      errors++;
      $display("FAIL bp_rd_en: got %0d (bad %0d) want 2 (0)", rd_cnt, rd_bad);
    end
  endtask

  task automatic test_drop_mid();
    do_reset();
    clear_idx();
    req_pid[11:8] = 4'hB;
    req_len[2*LW +: LW] = 7'd5;
    req = 4'b0100;
    capture(60, 1'b0, 1'b1);
    req = '0;
    checks++;
    if (timeout || done_vec !== 4'b0100) begin
      errors++;
      $display("FAIL drop_done: got %b want 0100", done_vec);
    end
    checks++;
    if (cap.size() != 8 || rd_cnt != 5) begin
      errors++;
      $display("FAIL drop_len: got %0d bytes %0d reads want 8 5",
               cap.size(), rd_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    do_reset();
    clear_idx();
    req_pid[7:4] = 4'h3;
    req_len[LW +: LW] = 7'd5;
    req = 4'b0010;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      txi.tx_ready = 1'b1;
      drive_data();
      #1;
      if (rd_en) begin
        n++;
        idx[1]++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL abort_reach: got %0d reads want 2", n);
    end
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    #1;
    checks++;
    if (done !== '0) begin
      errors++;
      $display("FAIL abort_done_pre: got %b want 0000", done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (txi.tx_valid !== 1'b0 || grant !== '0 || done !== '0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: v=%b grant=%b done=%b busy=%b want 0",
               txi.tx_valid, grant, done, busy);
    end
    reset = 1'b0;
    req_len = {7'd1, 7'd1, 7'd1, 7'd1};
    req = 4'b1111;
    capture(40, 1'b0, 1'b0);
    req = '0;
    checks++;
    if (timeout || grant_pid !== 4'b0001) begin
      errors++;
      $display("FAIL abort_rr: got %b want 0001", grant_pid);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    clear_idx();
    req_pid[15:12] = 4'h3;
    req_len[3*LW +: LW] = 7'd100;
    req = 4'b1000;
    capture(200, 1'b0, 1'b0);
    req = '0;
    checks++;
    if (timeout || rd_cnt != 64 || cap.size() != 67) begin
      errors++;
      $display("FAIL clamp: got %0d reads %0d bytes want 64 67",
               rd_cnt, cap.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    txi.tx_ready = 1'b0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 128; j++)
        mem[i][j] = 8'(i * 32 + j);
    clear_idx();
    test_reset();
    test_zero_len();
    test_crc_len9();
    test_round_robin();
    test_backpressure();
    test_drop_mid();
    test_reset_abort();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
- Shares the USB transmit byte path between NUM_REQ packet requesters using round-robin arbitration.
- For the granted requester it sequences one packet onto tx_data/tx_valid/tx_ready: PID byte, then payload bytes, then CRC16 low byte (CRC1), then CRC16 high byte (CRC2).
- It then enforces an inter-packet gap before re-arbitrating.
- It sits between the packet sources and the USB TX line interface and replaces the single-source send_data/tx_ready sequencer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 7, width of each payload length field
MAX_LEN, 64, maximum payload bytes; larger requested lengths are clamped to MAX_LEN
GAP_CYC, 4, idle cycles inserted after each packet (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester packet request, level
req_pid  in  4*NUM_REQ  per-requester 4-bit PID, slice i = bits [4i+3:4i]
req_len  in  LEN_W*NUM_REQ  per-requester payload length in bytes (0 legal)
req_data  in  8*NUM_REQ  per-requester current payload byte
grant  out  NUM_REQ  one-hot owner of the TX path
rd_en  out  1  payload byte consumed this cycle by the granted requester; it presents the next byte the following cycle
done  out  NUM_REQ  one-cycle pulse on the owner's bit when CRC2 transfers
tx_data  out  8  byte to the line interface
tx_valid  out  1  tx_data valid
tx_ready  in  1  line interface accepts the byte
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset the block enters IDLE with grant=0, rd_en=0, done=0, tx_valid=0, tx_data=0, busy=0. The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority. Reset mid-packet aborts the packet immediately with no done pulse.
- Transfer rule: a byte transfers in a cycle where tx_valid and tx_ready are both 1. While tx_valid=1 and tx_ready=0, tx_data and state are held.
- States: IDLE, PID, DATA, CRC1, CRC2, GAP.
- tx_valid=1 exactly in PID, DATA, CRC1 and CRC2.
- IDLE: if req!=0, pick the first set bit searching from ptr+1 upward with wrap-around. Register grant and ptr=winner, and latch pid, len (clamped) and cnt=len. Next state is PID. Requests are sampled only in IDLE.
- PID: tx_data = {~pid, pid}. On transfer, go to DATA if len!=0, otherwise to CRC1.
- DATA: tx_data = req_data slice of the owner. rd_en = transfer. On transfer, cnt decrements and the CRC updates. When cnt==1 the transfer moves the state to CRC1.
- CRC1: tx_data = ~crc[7:0]. On transfer, go to CRC2.
- CRC2: tx_data = ~crc[15:8]. On transfer, pulse done[owner], clear grant, load the gap counter with GAP_CYC, and go to GAP.
- GAP: the counter decrements each cycle; at 0 the state returns to IDLE. Minimum packet-to-packet spacing is therefore GAP_CYC+1 cycles of tx_valid=0.
- CRC: CRC-16/USB, reflected polynomial 0xA001, init 0xFFFF, computed over payload bytes only, LSB first, output inverted. The CRC is re-initialised in IDLE.
- Owner dropping req mid-packet: ignored; the packet completes.
- Owner changing req_pid or req_len mid-packet: ignored; both were latched in IDLE.
- Simultaneous requests: round-robin only; the owner of the previous packet is the lowest priority next.
- Zero-length packet: sequence is PID, CRC1=0x00, CRC2=0x00.
- Throughput: with tx_ready held at 1, a packet of len N occupies N+3 consecutive tx_valid cycles.

Decomposition:
- Package usb_tx_pkg holds the state enum constants (IDLE..GAP), CRC16_INIT=16'hFFFF, CRC16_POLY_R=16'hA001, and the PID constants OUT=4'h1, IN=4'h9, DATA0=4'h3, DATA1=4'hB.
- Sub-module usb_crc16_byte: combinational next-CRC from (crc_in[15:0], data[7:0]), instantiated once.

Test Plan:
- reset, req[0]=1, pid=DATA0, len=0, tx_ready=1 -> grant=0001 the cycle after IDLE sampling; tx_data sequence 0xC3, 0x00, 0x00; done[0] pulses with the CRC2 transfer; tx_valid=0 for 4 cycles afterwards.
- req[1]=1, pid=DATA1, len=9, bytes "123456789" -> 0x4B, 0x31..0x39, 0xC8, 0xB4; rd_en high on exactly 9 cycles.
- req=1111 held, len=1 each -> grant order 0001, 0010, 0100, 1000, 0001.
- len=2, tx_ready toggled 0/1 every cycle -> each byte is held stable while tx_ready=0; total 5 transfers; rd_en high only on transfer cycles.
- req[2] deasserted and req_len changed during DATA -> packet completes with the original length and done[2] pulses.
- reset asserted during DATA of a len=5 packet -> next cycle tx_valid=0 and grant=0; no done pulse; the next arbitration starts from requester 0.
- req_len=100 with MAX_LEN=64 -> exactly 64 payload bytes are transmitted.
